fir_shift_add_param: RTL

Parametrised shift-and-add FIR filter. It generalises the fixed 5-tap power-of-two filter to TAPS taps, WIDTH-bit samples and run-time programmable per-tap shift coefficients. It adds an input-valid handshake, flush, a primed status flag and a run-time selectable approximate-adder mode (lower-part OR adder) for accuracy/PPA studies. It sits in the FIR datapath between the sample source and the downstream error-measurement logic.

---
 rtl/fir_shift_add_param_if.sv | 28 ++
 rtl/fir_shift_add_param.sv | 94 +++++++++
 2 files changed

// File: rtl/fir_shift_add_param_if.sv
// Sample, control, coefficient-write and result signals of the shift-and-add FIR.
// The master is the sample source / configuration side; the slave is the filter.
interface fir_shift_add_param_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int AW    = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic             flush;
  logic             approx_en;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [SHW-1:0]   cfg_shift;
  logic [WIDTH-1:0] dataout;
  logic             out_valid;
  logic             primed;

  modport master (
    output in_valid, x, flush, approx_en, cfg_we, cfg_addr, cfg_shift,
    input  dataout, out_valid, primed
  );

  modport slave (
    input  in_valid, x, flush, approx_en, cfg_we, cfg_addr, cfg_shift,
    output dataout, out_valid, primed
  );
endinterface

// File: rtl/fir_shift_add_param.sv
// Parametrised shift-and-add FIR. Each tap is a logical right shift of a
// delayed sample by a run-time programmable amount; the terms are summed in a
// fixed chain of exact or lower-part-OR approximate adders and registered.
module fir_shift_add_param #(
  parameter int TAPS     = 5,
  parameter int WIDTH    = 16,
  parameter int SHW      = 4,
  parameter int APX_BITS = 4
) (
  input logic                   clk,
  input logic                   rst,
  fir_shift_add_param_if.slave  bus
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0]    LAST     = AW'(TAPS - 1);
  localparam logic [WIDTH-1:0] LO_MASK  = {WIDTH{1'b1}} >> (WIDTH - APX_BITS);
  localparam logic [WIDTH-1:0] CARRY_IN = WIDTH'(1) << APX_BITS;
  localparam int               CBIT     = (APX_BITS > 0) ? APX_BITS - 1 : 0;

  logic [SHW-1:0]   sh   [TAPS];
  logic [WIDTH-1:0] dly  [1:TAPS-1];
  logic [WIDTH-1:0] term [TAPS];
  logic [WIDTH-1:0] acc;
  logic [AW-1:0]    fill;
  logic             accept;

  // Lower-part OR adder: low bits are a|b, the carry into the upper part is
  // generated from the top approximate bit pair only.
  function automatic logic [WIDTH-1:0] tap_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             apx);
    logic [WIDTH-1:0] hi;
    if (!apx || APX_BITS == 0) return a + b;
    hi = (a & ~LO_MASK) + (b & ~LO_MASK) + ((a[CBIT] & b[CBIT]) ? CARRY_IN : '0);
    return ((a | b) & LO_MASK) | (hi & ~LO_MASK);
  endfunction

  // Reset coefficient for tap k: TAPS-k, clipped to the coefficient range.
  function automatic logic [SHW-1:0] sh_init(input int k);
    int v;
    int mx;
    v  = TAPS - k;
    mx = (1 << SHW) - 1;
    return SHW'((v > mx) ? mx : v);
  endfunction

  assign accept     = bus.in_valid & ~bus.flush;
  assign bus.primed = (fill == LAST);

  // Shift terms and the accumulation chain for the current input sample.
  always_comb begin
    term[0] = bus.x >> sh[0];
    for (int k = 1; k < TAPS; k++) term[k] = dly[k] >> sh[k];
    acc = term[0];
    for (int k = 1; k < TAPS; k++) acc = tap_add(acc, term[k], bus.approx_en);
  end

  // Coefficient register file; out-of-range addresses are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) sh[k] <= sh_init(k);
    end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < (AW + 1)'(TAPS))) begin
      sh[bus.cfg_addr] <= bus.cfg_shift;
    end
  end

  // Delay line and saturating fill counter; flush clears both and drops the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k < TAPS; k++) dly[k] <= '0;
      fill <= '0;
    end else if (bus.flush) begin
      for (int k = 1; k < TAPS; k++) dly[k] <= '0;
      fill <= '0;
    end else if (bus.in_valid) begin
      dly[1] <= bus.x;
      for (int k = 2; k < TAPS; k++) dly[k] <= dly[k-1];
      if (fill != LAST) fill <= fill + 1'b1;
    end
  end

  // Result register: updated and flagged only for accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dataout   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      if (accept) bus.dataout <= acc;
    end
  end

endmodule
